// File: rtl/pdp6_dly_pkg.sv
// Shared constants and tap-length helper for the PDP-6 pulse delay line.
// Optional level outputs are enabled with the DLY_LEVEL_EN macro.
package pdp6_dly_pkg;

    localparam int unsigned CLK_NS_DEF = 10;
    localparam int unsigned D1_NS_DEF  = 100;
    localparam int unsigned D2_NS_DEF  = 150;

    // Whole clock cycles covering d_ns, never fewer than one.
    function automatic int unsigned dly_cycles(
        input int unsigned d_ns,
        input int unsigned clk_ns
    );
        int unsigned c;
        if (clk_ns == 0) begin
            c = 1;
        end else begin
            c = (d_ns + clk_ns - 1) / clk_ns;
        end
        if (c == 0) begin
            c = 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/dly_tap.sv
// One retriggerable delay tap: a start loads N, the 1->0 step emits a pulse.
// With DLY_LEVEL_EN the tap also exports a busy level.
module dly_tap
    import pdp6_dly_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef DLY_LEVEL_EN
    output logic level,
`endif
    output logic pulse
);

    localparam int unsigned NN = (N < 1) ? 1 : N;
    localparam int unsigned W  = $clog2(NN + 1);
    localparam logic [W-1:0] LOAD = W'(NN);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         pulse_q;
    logic         pulse_d;

    // A start on the terminal step reloads and suppresses the pulse.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (start) begin
            cnt_d = LOAD;
        end else if (cnt_q != ZERO) begin
            cnt_d   = cnt_q - ONE;
            pulse_d = (cnt_q == ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= ZERO;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

`ifdef DLY_LEVEL_EN
    logic level_q;
    logic level_d;

    always_comb begin
        level_d = (cnt_d != ZERO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: rtl/pulse_dly_100_150.sv
// Two-tap retriggerable pulse delay (100 ns / 150 ns) for PDP-6 timing.
// Define DLY_LEVEL_EN to add the lv100ns / lv150ns level outputs.
module pulse_dly_100_150
    import pdp6_dly_pkg::*;
#(
    parameter int unsigned CLK_NS = CLK_NS_DEF,
    parameter int unsigned D1_NS  = D1_NS_DEF,
    parameter int unsigned D2_NS  = D2_NS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
`ifdef DLY_LEVEL_EN
    output logic lv100ns,
    output logic lv150ns,
`endif
    output logic out100ns,
    output logic out150ns
);

    localparam int unsigned N1 = dly_cycles(D1_NS, CLK_NS);
    localparam int unsigned N2 = dly_cycles(D2_NS, CLK_NS);

    logic trig_d_q;
    logic trig_d_d;
    logic trigger;

    // trig_d resets high so a level already present at release is ignored.
    always_comb begin
        trig_d_d = trig;
        trigger  = trig & ~trig_d_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_d_q <= 1'b1;
        end else begin
            trig_d_q <= trig_d_d;
        end
    end

    dly_tap #(
        .N(N1)
    ) u_tap1 (
        .clk  (clk),
        .reset(reset),
        .start(trigger),
`ifdef DLY_LEVEL_EN
        .level(lv100ns),
`endif
        .pulse(out100ns)
    );

    dly_tap #(
        .N(N2)
    ) u_tap2 (
        .clk  (clk),
        .reset(reset),
        .start(trigger),
`ifdef DLY_LEVEL_EN
        .level(lv150ns),
`endif
        .pulse(out150ns)
    );

endmodule

// File: tb/tb_pulse_dly_100_150.sv
// Scoreboard bench for pulse_dly_100_150: deadline-based reference model,
// directed scenarios followed by randomized trig/reset traffic.
module tb_pulse_dly_100_150;

    logic clk;
    logic reset;
    logic trig;
    logic out100ns;
    logic out150ns;
`ifdef DLY_LEVEL_EN
    logic lv100ns;
    logic lv150ns;
`endif

    pulse_dly_100_150 dut (
        .clk     (clk),
        .reset   (reset),
        .trig    (trig),
`ifdef DLY_LEVEL_EN
        .lv100ns (lv100ns),
        .lv150ns (lv150ns),
`endif
        .out100ns(out100ns),
        .out150ns(out150ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int  edge_no;
        bit  p1;
        bit  p2;
        bit  l1;
        bit  l2;
    } exp_t;

    exp_t exp_q[$];

    int  n_vec;
    int  n_bad;
    int  now;
    bit  prev_trig;
    int  dl[2];
    int  taps[2];

    // Reference: each tap remembers the absolute edge its pulse is due.
    task automatic step(input bit t, input bit r);
        exp_t e;
        bit   trg;
        trig  = t;
        reset = r;
        @(posedge clk);
        now++;
        e.edge_no = now;
        e.p1 = 0;
        e.p2 = 0;
        e.l1 = 0;
        e.l2 = 0;
        if (r) begin
            prev_trig = 1;
            dl[0] = -1;
            dl[1] = -1;
        end else begin
            trg = t && !prev_trig;
            prev_trig = t;
            for (int i = 0; i < 2; i++) begin
                bit p;
                bit l;
                p = !trg && (dl[i] == now);
                if (trg) dl[i] = now + taps[i];
                l = dl[i] > now;
                if (i == 0) begin
                    e.p1 = p;
                    e.l1 = l;
                end else begin
                    e.p2 = p;
                    e.l2 = l;
                end
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic high(input int n);
        for (int i = 0; i < n; i++) step(1, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (out100ns !== e.p1) begin
                n_bad++;
                $display("FAIL out100ns edge %0d: got %b want %b",
                         e.edge_no, out100ns, e.p1);
            end
            if (out150ns !== e.p2) begin
                n_bad++;
                $display("FAIL out150ns edge %0d: got %b want %b",
                         e.edge_no, out150ns, e.p2);
            end
`ifdef DLY_LEVEL_EN
            if (lv100ns !== e.l1) begin
                n_bad++;
                $display("FAIL lv100ns edge %0d: got %b want %b",
                         e.edge_no, lv100ns, e.l1);
            end
            if (lv150ns !== e.l2) begin
                n_bad++;
                $display("FAIL lv150ns edge %0d: got %b want %b",
                         e.edge_no, lv150ns, e.l2);
            end
`endif
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        now = 0;
        prev_trig = 1;
        dl[0] = -1;
        dl[1] = -1;
        taps[0] = (100 + 10 - 1) / 10;
        taps[1] = (150 + 10 - 1) / 10;
        trig = 0;
        reset = 1;

        // Reset state, then a single trigger two cycles after release.
        step(0, 1);
        step(0, 1);
        idle(2);
        high(3);
        idle(25);

        // Retrigger five cycles after the first edge.
        step(1, 0);
        idle(4);
        step(1, 0);
        idle(25);

        // Retrigger landing exactly on the 100 ns terminal step.
        step(1, 0);
        idle(9);
        step(1, 0);
        idle(25);

        // Held high for 40 cycles gives one pulse per tap.
        high(40);
        idle(20);

        // trig already high while reset releases.
        step(1, 1);
        high(30);
        idle(5);

        // Reset seven cycles after a trigger, released next cycle.
        step(1, 0);
        idle(6);
        step(0, 1);
        idle(25);

        // Randomized traffic with rare resets.
        for (int k = 0; k < 3000; k++) begin
            bit t;
            bit r;
            t = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 299) == 0);
            step(t, r);
        end
        idle(20);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
